// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous BCD snapshots.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    output logic [6:0] seg_out,
    output logic [3:0] dig_out
);

    localparam logic [15:0] CntMax   = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SegDark  = 7'b1111111;
    localparam logic [3:0]  DigDark  = 4'b1111;

    logic [15:0]     cnt_q, cnt_d;
    logic            tick;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] snap_q, snap_d;
    logic [6:0]      seg_d;
    logic [3:0]      dig_d;
    logic [3:0]      cur_digit;
    logic            blank;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Prescaler, scan index and snapshot next-state.
    always_comb begin
        tick   = en && (cnt_q == CntMax);
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (en) begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        end
        if (tick) begin
            idx_d = idx_q + 2'd1;
            // Capture on the wrap so a whole frame shows one consistent value set.
            if (idx_q == 2'd3) begin
                snap_d = {bcd3, bcd2, bcd1, bcd0};
            end
        end
    end

    always_comb begin
        cur_digit = snap_q[idx_q];
`ifdef SEG7_SCAN_LZB_EN
        case (idx_q)
            2'd3:    blank = (snap_q[3] == 4'd0);
            2'd2:    blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
            2'd1:    blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0) &&
                             (snap_q[1] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    // Output next-state: strobe follows idx_q, so outputs trail idx by one clk.
    always_comb begin
        seg_d = SegDark;
        dig_d = DigDark;
        if (en) begin
            dig_d = ~(4'b0001 << idx_q);
            seg_d = blank ? SegDark : decode(cur_digit);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 16'd0;
            idx_q   <= 2'd0;
            snap_q  <= '0;
            seg_out <= SegDark;
            dig_out <= DigDark;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_out <= seg_d;
            dig_out <= dig_d;
        end
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  scan enable; 1 = scanning, 0 = display dark and prescaler frozen.
REQ-005 bcd0  input  4  ones digit, driven by an upstream BCD counter.
REQ-006 bcd1  input  4  tens digit.
REQ-007 bcd2  input  4  hundreds digit.
REQ-008 bcd3  input  4  thousands digit.
REQ-009 seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-010 dig_out  output  4  digit strobes, one-hot active-low; bit n selects digit n.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 while en=1, wrap to 0, and assert internal tick in the cycle it equals SCAN_DIV-1; with SCAN_DIV=1, tick SHALL be asserted every en=1 cycle.
REQ-012 Scan index idx (2 bits) SHALL advance by 1 on each tick and wrap 3->0.
REQ-013 On the tick taking idx 3->0, all four bcd inputs SHALL be captured into snapshot registers; displayed digits SHALL come only from snapshots (no tearing within a frame).
REQ-014 seg_out and dig_out SHALL be registered, reflecting the new idx exactly one clk after idx changes.
REQ-015 dig_out SHALL drive 0 only on bit idx and 1 on all other bits while en=1.
REQ-016 Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 Snapshot values 10..15 SHALL display dash 0111111.
REQ-018 When en=0, prescaler and idx SHALL hold, dig_out SHALL be 1111 and seg_out 1111111 from the next clk; snapshots SHALL hold.
REQ-019 When en returns to 1, scanning SHALL resume from the held prescaler and idx values, outputs restored within one clk.
REQ-020 An input change during a frame SHALL first be displayed in the frame after the next 3->0 wrap.

Reset
REQ-021 While reset=0: prescaler=0, idx=0, snapshots=0, seg_out=1111111, dig_out=1111, independent of clk.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately; after release, first tick occurs SCAN_DIV en=1 cycles later with idx 0->1.
REQ-023 Between reset release and first output update, outputs SHALL remain dark (all 1).

Configuration
REQ-024 Macro SEG7_SCAN_LZB_EN SHALL enable leading-zero blanking: digit n (n=3,2,1) shows 1111111 when its snapshot and all higher snapshots are 0; digit 0 never blanked.
REQ-025 Without SEG7_SCAN_LZB_EN, all four digits SHALL always be decoded per REQ-016/REQ-017.
REQ-026 Blanking SHALL blank segments only; dig_out strobing SHALL be unchanged.

Verification (SCAN_DIV=4)
REQ-027 Reset low, toggle clk -> seg_out=1111111, dig_out=1111; release, en=1 -> dig_out steps 1110,1101,1011,0111,1110 every 4 clks.
REQ-028 bcd3..0=1,2,3,4, run two frames -> digit strobes 1110/1101/1011/0111 show 0011001/0110000/0100100/1111001.
REQ-029 bcd0 set to 12 -> after next wrap digit 0 shows 0111111.
REQ-030 Change bcd1 5->7 while idx=2 -> digit 1 shows 5 for rest of frame, 7 after wrap.
REQ-031 en=0 for 10 clks mid-frame -> dark outputs, idx held; en=1 -> same digit resumes.
REQ-032 With SEG7_SCAN_LZB_EN, bcd=0,0,4,0 (3..0) -> digits 3,2 blank, digit 1 0011001, digit 0 1000000; without macro digits 3,2 show 1000000.
